// File: rtl/pwm_gen.sv
// pwm_gen: prescaled PWM generator with double-buffered duty; PWM_DEADTIME_EN adds dead-time outputs
module pwm_gen #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1,
  parameter int DEADTIME = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
  output logic             pwm_out_n,
  output logic             period_start
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0]    psc;
  logic [WIDTH-1:0] cnt, duty_active, pending;
  logic             pending_full, tick, wrap, wrapped, raw;
  assign tick       = psc == PW'(PRESCALE - 1);
  assign wrap       = tick && cnt == '1;
  assign raw        = cnt < duty_active;
  assign duty_ready = ~pending_full;
  // prescaler and period counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      psc <= '0;
      cnt <= '0;
    end else begin
      psc <= tick ? '0 : psc + 1'b1;
      if (tick) cnt <= cnt + 1'b1;
    end
  // pending slot filled by handshake, drained into the active duty only at wrap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending      <= '0;
      pending_full <= 1'b0;
      duty_active  <= '0;
    end else if (wrap && pending_full) begin
      duty_active  <= pending;
      pending_full <= 1'b0;
    end else if (duty_valid && !pending_full) begin
      pending      <= duty_in;
      pending_full <= 1'b1;
    end
  // period_start delayed one extra clock so it lines up with the registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wrapped      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      wrapped      <= wrap;
      period_start <= wrapped;
    end
`ifdef PWM_DEADTIME_EN
  localparam int DW = $clog2(DEADTIME + 2);
  logic          raw_q;
  logic [DW-1:0] run_q, run;
  // clocks raw has held its current level, saturating just past the dead time
  always_comb run = raw != raw_q ? DW'(1) : run_q > DW'(DEADTIME) ? run_q : run_q + 1'b1;
  // an output may go high only once raw has been stable longer than the dead time
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      raw_q     <= 1'b0;
      run_q     <= '0;
      pwm_out   <= 1'b0;
      pwm_out_n <= 1'b0;
    end else begin
      raw_q     <= raw;
      run_q     <= run;
      pwm_out   <= raw && run > DW'(DEADTIME);
      pwm_out_n <= !raw && run > DW'(DEADTIME);
    end
`else
  // registered exact complement outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pwm_out   <= 1'b0;
      pwm_out_n <= 1'b0;
    end else begin
      pwm_out   <= raw;
      pwm_out_n <= ~raw;
    end
`endif
endmodule
